// File: rtl/led_byte_feeder_pkg.sv
// Shared definitions for the LED-64 byte feeder.
// Contents:
//   state_e        - feeder FSM encoding (LOAD, START, WAIT, UNLOAD), 2 bits
//   BLK_W, BYTE_W  - block/key width and bus byte width
//   NBYTES         - bytes per block
//   CORE_LAT_DEF   - default core latency (1 load + 32 rounds)
//   shift_in_byte  - shift a block left by one byte, new byte in the LS byte
package led_byte_feeder_pkg;

  localparam int BLK_W        = 64;
  localparam int BYTE_W       = 8;
  localparam int NBYTES       = BLK_W / BYTE_W;
  localparam int CORE_LAT_DEF = 33;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  function automatic logic [BLK_W-1:0] shift_in_byte(
    input logic [BLK_W-1:0]  word,
    input logic [BYTE_W-1:0] b
  );
    return {word[BLK_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/led_shift_byte_reg.sv
// 64-bit byte shift register with a byte counter.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_i       - parallel load of load_data_i; clears the count
//   load_data_i  - parallel load value
//   shift_i      - shift left by one byte, byte_i enters the LS byte; count+1
//   byte_i       - byte shifted in
//   clr_cnt_i    - clear the count only (contents retained)
//   data_o       - current register contents
//   cnt_o        - bytes shifted since the last load/clear
// With WRAP=1 the count runs 0..7 and wraps, so a count of 0 marks a
// byte boundary of a complete word; with WRAP=0 it stops meaningfully at 8.
module led_shift_byte_reg
  import led_byte_feeder_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [BLK_W-1:0]  load_data_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              clr_cnt_i,
  output logic [BLK_W-1:0]  data_o,
  output logic [3:0]        cnt_o
);

  logic [BLK_W-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = shift_in_byte(data_q, byte_i);
      cnt_d  = (WRAP && cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
    end else if (clr_cnt_i) begin
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/led_byte_feeder.sv
// Byte-serial front end for the LED-64 core.
// Collects a 64-bit key and plaintext from an 8-bit valid/ready stream
// (first byte lands in [63:56]), pulses core_start, waits CORE_LAT cycles,
// captures core_result and streams it out MS byte first.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_data/in_is_key     - input byte and its destination (1 = key)
//   in_valid/in_ready     - input handshake
//   core_a/core_k         - plaintext/key to the core (held outside LOAD)
//   core_start            - one-cycle launch pulse
//   core_result           - ciphertext from the core
//   out_data/out_valid    - ciphertext byte stream
//   out_ready             - sink ready
// The key is retained between blocks; only a reset or a fresh 8-byte key
// replaces it.
module led_byte_feeder
  import led_byte_feeder_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_is_key,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BLK_W-1:0]  core_a,
  output logic [BLK_W-1:0]  core_k,
  output logic              core_start,
  input  logic [BLK_W-1:0]  core_result,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [7:0] WAIT_INIT = 8'(CORE_LAT - 1);

  state_e              state_q, state_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                key_ok_q, key_ok_d;

  logic [BLK_W-1:0]    blk_word, key_word, out_word;
  logic [3:0]          dcnt, kcnt, ocnt;
  logic [BYTE_W-1:0]   out_msb;
  logic [BLK_W-BYTE_W-1:0] out_rest_unused;

  logic key_xfer, dat_xfer, out_xfer;
  logic blk_full, key_first, key_last, out_last;
  logic blk_clr, out_load;

  // ---------------------------------------------------------------- datapath
  led_shift_byte_reg #(.WRAP(1'b1)) u_key_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (key_xfer),
    .byte_i      (in_data),
    .clr_cnt_i   (1'b0),
    .data_o      (key_word),
    .cnt_o       (kcnt)
  );

  led_shift_byte_reg #(.WRAP(1'b0)) u_blk_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (dat_xfer),
    .byte_i      (in_data),
    .clr_cnt_i   (blk_clr),
    .data_o      (blk_word),
    .cnt_o       (dcnt)
  );

  led_shift_byte_reg #(.WRAP(1'b0)) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (out_load),
    .load_data_i (core_result),
    .shift_i     (out_xfer),
    .byte_i      ('0),
    .clr_cnt_i   (1'b0),
    .data_o      (out_word),
    .cnt_o       (ocnt)
  );

  assign {out_msb, out_rest_unused} = out_word;

  assign blk_full  = (dcnt == 4'd8);
  assign key_first = (kcnt == 4'd0);
  assign key_last  = (kcnt == 4'd7);
  assign out_last  = (ocnt == 4'd7);

  // in_ready already encodes the state, so the transfers need no state term.
  assign key_xfer = in_valid & in_ready & in_is_key;
  assign dat_xfer = in_valid & in_ready & ~in_is_key;
  assign out_xfer = out_valid & out_ready;
  assign blk_clr  = out_xfer & out_last;
  assign out_load = (state_q == ST_WAIT) && (wcnt_q == 8'd0);

  assign core_a = blk_word;
  assign core_k = key_word;

  // ------------------------------------------------------------- FSM: state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // A key byte taken in the exit cycle restarts the key, so launching
      // waits for that new key to complete.
      ST_LOAD:   if (blk_full && key_ok_q && !key_xfer) state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT:   if (wcnt_q == 8'd0) state_d = ST_UNLOAD;
      ST_UNLOAD: if (out_xfer && out_last) state_d = ST_LOAD;
      default:   state_d = ST_LOAD;
    endcase
  end

  // ----------------------------------------------------------- FSM: outputs
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      // Combinational in_is_key -> in_ready: key bytes are never blocked in
      // LOAD, data bytes only until the block is full.
      ST_LOAD:   in_ready = rst_n & (in_is_key | ~blk_full);
      ST_START:  core_start = 1'b1;
      ST_WAIT:   ;
      ST_UNLOAD: out_valid = 1'b1;
      default:   ;
    endcase
  end

  assign out_data = out_valid ? out_msb : '0;

  // ---------------------------------------------- wait counter and key flag
  always_comb begin
    wcnt_d   = wcnt_q;
    key_ok_d = key_ok_q;
    if (state_q == ST_START) begin
      wcnt_d = WAIT_INIT;
    end else if (state_q == ST_WAIT && wcnt_q != 8'd0) begin
      wcnt_d = wcnt_q - 8'd1;
    end
    if (key_xfer) begin
      if (key_first) key_ok_d = 1'b0;
      if (key_last)  key_ok_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      key_ok_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      key_ok_q <= key_ok_d;
    end
  end

endmodule
